// File: rtl/i2c_req_arbiter.sv
// ---------------------------------------------------------------------------
// i2c_req_arbiter
//   Shares one I2C master between NUM_REQ requesters. A round-robin winner is
//   picked in IDLE, its address/byte are frozen and launched to the master,
//   and the result is returned with a one-cycle done pulse. A per-transaction
//   timeout aborts a master that never starts or never finishes.
//
// Ports
//   clk, rst          clock, asynchronous active-high reset
//   req               per-requester request level
//   req_addr          packed slave addresses, slice i = requester i
//   req_wdata         packed write bytes, slice i = requester i
//   gnt               one-hot grant (zero when idle)
//   done              one-cycle completion pulse to the granted requester
//   rdata, ack_o      byte and acknowledge captured at completion
//   err               pulses with done when the transaction timed out
//   m_start           start strobe to the master (LAUNCH only)
//   m_slave_addr      frozen address to the master
//   m_data_in         frozen write byte to the master
//   m_data_out        read byte from the master
//   m_busy, m_ack     master busy flag and acknowledge
//   dbg_state_o       current FSM state, for observation only
//
// Handshake: a requester raises req and keeps its addr/wdata valid until it
// sees gnt; from then on the arbiter owns a private copy, so req and the
// inputs may change freely. The transaction always ends with exactly one
// done pulse on the granted bit (unless reset intervenes), and gnt drops the
// cycle after done.
// ---------------------------------------------------------------------------
module i2c_req_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_WIDTH     = 8,
  parameter int ADDR_WIDTH     = 7,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic                          ack_o,
  output logic                          err,
  output logic                          m_start,
  output logic [ADDR_WIDTH-1:0]         m_slave_addr,
  output logic [DATA_WIDTH-1:0]         m_data_in,
  input  logic [DATA_WIDTH-1:0]         m_data_out,
  input  logic                          m_busy,
  input  logic                          m_ack,
  output logic [2:0]                    dbg_state_o
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_RST    = IDX_W'(NUM_REQ - 1);
  localparam logic [15:0]      TIMEOUT_VAL = 16'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_COMPLETE  = 3'd4
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_REQ-1:0]      gnt_q, gnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [IDX_W-1:0]        last_gnt_q, last_gnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    ack_q, ack_d;
  logic                    err_armed_q, err_armed_d;
  logic [15:0]             cnt_q, cnt_d;
  logic [15:0]             cnt_inc;

  logic                    win_found;
  logic [IDX_W-1:0]        win_idx;

  // Round-robin pick: scan from the requester after the last winner, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      int cand;
      cand = (int'(last_gnt_q) + k) % NUM_REQ;
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    idx_d       = idx_q;
    last_gnt_d  = last_gnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rdata_d     = rdata_q;
    ack_d       = ack_q;
    err_armed_d = err_armed_q;
    cnt_d       = cnt_q;
    // Saturating increment so a huge TIMEOUT_CYCLES never wraps.
    cnt_inc     = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d        = S_LAUNCH;
          gnt_d          = '0;
          gnt_d[win_idx] = 1'b1;
          idx_d          = win_idx;
          addr_d         = req_addr[win_idx*ADDR_WIDTH +: ADDR_WIDTH];
          wdata_d        = req_wdata[win_idx*DATA_WIDTH +: DATA_WIDTH];
          err_armed_d    = 1'b0;
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY, S_WAIT_DONE: begin
        cnt_d = cnt_inc;
        // Timeout takes priority over any master activity in the same cycle.
        if (cnt_inc == TIMEOUT_VAL) begin
          state_d     = S_COMPLETE;
          err_armed_d = 1'b1;
          rdata_d     = '0;
          ack_d       = 1'b0;
        end else if (state_q == S_WAIT_BUSY) begin
          if (m_busy) state_d = S_WAIT_DONE;
        end else if (!m_busy) begin
          state_d = S_COMPLETE;
          rdata_d = m_data_out;
          ack_d   = m_ack;
        end
      end
      S_COMPLETE: begin
        last_gnt_d  = idx_q;
        gnt_d       = '0;
        err_armed_d = 1'b0;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      idx_q       <= '0;
      last_gnt_q  <= LAST_RST;
      addr_q      <= '0;
      wdata_q     <= '0;
      rdata_q     <= '0;
      ack_q       <= 1'b0;
      err_armed_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      idx_q       <= idx_d;
      last_gnt_q  <= last_gnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      ack_q       <= ack_d;
      err_armed_q <= err_armed_d;
      cnt_q       <= cnt_d;
    end
  end

  // Strobes are pure decodes of the registered state, so they are one cycle
  // wide by construction and vanish immediately on reset.
  assign gnt          = gnt_q;
  assign done         = (state_q == S_COMPLETE) ? gnt_q : '0;
  assign err          = (state_q == S_COMPLETE) && err_armed_q;
  assign m_start      = (state_q == S_LAUNCH);
  assign m_slave_addr = addr_q;
  assign m_data_in    = wdata_q;
  assign rdata        = rdata_q;
  assign ack_o        = ack_q;
  assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_i2c_req_arbiter
//   Directed and randomized transactions against a behavioural model of the
//   arbiter. The driver predicts each transaction (winner, frozen address and
//   byte, returned data, launch and done cycles) and pushes it to exp_q; a
//   monitor compares the DUT at every negedge. A small master model plays the
//   I2C master: normal, never-busy and stuck-busy behaviours.
// ---------------------------------------------------------------------------
module tb_i2c_req_arbiter;

  localparam int N  = 4;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int T  = 31;
  localparam int EXP_W = 3 + AW + DW + DW + 1 + 1;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req;
  logic [N*AW-1:0]   req_addr;
  logic [N*DW-1:0]   req_wdata;
  logic [N-1:0]      gnt;
  logic [N-1:0]      done;
  logic [DW-1:0]     rdata;
  logic              ack_o;
  logic              err;
  logic              m_start;
  logic [AW-1:0]     m_slave_addr;
  logic [DW-1:0]     m_data_in;
  logic [DW-1:0]     m_data_out;
  logic              m_busy;
  logic              m_ack;
  logic [2:0]        dbg_state;

  i2c_req_arbiter #(
    .NUM_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_wdata(req_wdata),
    .gnt(gnt), .done(done), .rdata(rdata), .ack_o(ack_o), .err(err),
    .m_start(m_start), .m_slave_addr(m_slave_addr), .m_data_in(m_data_in),
    .m_data_out(m_data_out), .m_busy(m_busy), .m_ack(m_ack),
    .dbg_state_o(dbg_state)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard state ----------------
  // exp_q entry: {winner[2:0], addr[6:0], wdata[7:0], rdata[7:0], ack, err}
  logic [EXP_W-1:0] exp_q[$];
  int               exp_launch_q[$];
  int               exp_done_q[$];
  // plan entry for the master model: {mode[1:0], rise[3:0], len[7:0], ack, rdata[7:0]}
  logic [22:0]      plan_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int last_gnt = N - 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  task automatic flush_model();
    exp_q.delete();
    exp_launch_q.delete();
    exp_done_q.delete();
    plan_q.delete();
  endtask

  // Winner = pending requester at the smallest circular distance after the
  // previous winner.
  function automatic int model_winner(input logic [N-1:0] mask);
    int best, best_d, d;
    best   = -1;
    best_d = N;
    for (int i = 0; i < N; i++) begin
      if (mask[i]) begin
        d = (i - last_gnt - 1 + 2 * N) % N;
        if (d < best_d) begin
          best_d = d;
          best   = i;
        end
      end
    end
    return best;
  endfunction

  task automatic randomize_inputs();
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW]  = 7'($urandom);
      req_wdata[i*DW +: DW] = 8'($urandom);
    end
  endtask

  // Issue one transaction. Must be called at posedge+#1 of an idle cycle;
  // returns at posedge+#1 of the idle cycle after done, with req cleared.
  // mode 0: normal (busy rises after `rise` cycles, stays `len` cycles)
  // mode 1: master never goes busy; mode 2: busy stuck past the timeout.
  task automatic do_txn(input logic [N-1:0] mask, input int mode, input int rise,
                        input int len, input logic [7:0] rd, input logic ack,
                        input bit perturb);
    int win, s, n;
    logic [AW-1:0] a;
    logic [DW-1:0] w;
    win = model_winner(mask);
    a = req_addr[win*AW +: AW];
    w = req_wdata[win*DW +: DW];
    if (mode == 0) exp_q.push_back({3'(win), a, w, rd, ack, 1'b0});
    else           exp_q.push_back({3'(win), a, w, 8'h00, 1'b0, 1'b1});
    plan_q.push_back({2'(mode), 4'(rise), 8'(len), ack, rd});
    s = cyc;
    exp_launch_q.push_back(s + 1);
    exp_done_q.push_back(mode == 0 ? s + 1 + rise + len + 1 : s + 1 + T + 1);
    req = mask;
    n = 0;
    while (n < 200) begin
      @(negedge clk);
      if (done != '0) break;
      n++;
      // Mid-transaction: winner drops req and every input slice changes.
      if (perturb && n == 3) begin
        req[win] = 1'b0;
        randomize_inputs();
      end
    end
    if (n >= 200) begin
      fail_now("txn_done_timeout");
      flush_model();
    end
    @(posedge clk);
    #1;
    req = '0;
    last_gnt = win;
  endtask

  // ---------------- master model ----------------
  initial begin
    logic [22:0] p;
    logic [1:0]  mode;
    int          rise, len, w;
    m_busy = 1'b0;
    m_data_out = '0;
    m_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && m_start && plan_q.size() != 0) begin
        p    = plan_q.pop_front();
        mode = p[22:21];
        rise = int'(p[20:17]);
        len  = int'(p[16:9]);
        if (mode != 2'd0) begin
          // Junk on the bus so a timeout must really clear rdata/ack_o.
          m_data_out = 8'($urandom) | 8'h01;
          m_ack      = 1'b1;
        end
        repeat (rise) @(posedge clk);
        #1;
        if (mode == 2'd0) begin
          m_busy = 1'b1;
          repeat (len) @(posedge clk);
          #1;
          m_busy     = 1'b0;
          m_data_out = p[7:0];
          m_ack      = p[8];
        end else begin
          if (mode == 2'd2) m_busy = 1'b1;
          w = 0;
          while (done == '0 && w < T + 20) begin
            @(negedge clk);
            w++;
          end
          @(posedge clk);
          #1;
          m_busy = 1'b0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [EXP_W-1:0] e;
    if (!rst) begin
      check("gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
      check("done_onehot", 32'($countones(done) <= 1), 32'd1);
      if (done == '0) check("err_without_done", 32'(err), 32'd0);
      if (m_start) begin
        if (exp_q.size() == 0) fail_now("unexpected_m_start");
        else begin
          e = exp_q[0];
          check("start_gnt", 32'(gnt), 32'd1 << e[27:25]);
          check("start_addr", 32'(m_slave_addr), 32'(e[24:18]));
          check("start_wdata", 32'(m_data_in), 32'(e[17:10]));
          check("launch_cycle", 32'(cyc), 32'(exp_launch_q[0]));
        end
      end else if (gnt != '0 && exp_q.size() != 0) begin
        e = exp_q[0];
        check("hold_gnt", 32'(gnt), 32'd1 << e[27:25]);
        check("hold_addr", 32'(m_slave_addr), 32'(e[24:18]));
        check("hold_wdata", 32'(m_data_in), 32'(e[17:10]));
      end
      if (done != '0) begin
        if (exp_q.size() == 0) fail_now("unexpected_done");
        else begin
          e = exp_q.pop_front();
          check("done_onehot_value", 32'(done), 32'd1 << e[27:25]);
          check("done_rdata", 32'(rdata), 32'(e[9:2]));
          check("done_ack", 32'(ack_o), 32'(e[1]));
          check("done_err", 32'(err), 32'(e[0]));
          check("done_cycle", 32'(cyc), 32'(exp_done_q[0]));
          void'(exp_launch_q.pop_front());
          void'(exp_done_q.pop_front());
        end
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    $display("FAIL watchdog_expired (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [N-1:0] mask;
    int win, r, mode;
    rst = 1'b1;
    req = '0;
    req_addr = '0;
    req_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_ack", 32'(ack_o), 32'd0);
    check("rst_rdata", 32'(rdata), 32'd0);
    check("rst_m_start", 32'(m_start), 32'd0);
    check("rst_m_addr", 32'(m_slave_addr), 32'd0);
    check("rst_m_data_in", 32'(m_data_in), 32'd0);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // Contention: all four held -> 0,1,2,3,0.
    for (int i = 0; i < 5; i++) begin
      randomize_inputs();
      do_txn(4'b1111, 0, 1, $urandom_range(1, 6), 8'($urandom), 1'($urandom), 1'b0);
    end

    // Single request, 20-cycle busy, returns 3C with ack.
    randomize_inputs();
    req_addr[2*AW +: AW]  = 7'h50;
    req_wdata[2*DW +: DW] = 8'hA5;
    do_txn(4'b0100, 0, 1, 20, 8'h3C, 1'b1, 1'b0);

    // Master never goes busy -> timeout.
    randomize_inputs();
    do_txn(4'b0010, 1, 1, 0, 8'h00, 1'b0, 1'b0);

    // Busy stuck past the timeout, then a normal transaction follows.
    randomize_inputs();
    do_txn(4'b1000, 2, 2, 0, 8'h00, 1'b0, 1'b0);
    randomize_inputs();
    do_txn(4'b1001, 0, 2, 5, 8'h5A, 1'b1, 1'b0);

    // Requester 2 drops req and changes its inputs mid-transaction.
    randomize_inputs();
    do_txn(4'b0100, 0, 1, 8, 8'hC3, 1'b0, 1'b1);

    // Randomized phase.
    for (int t = 0; t < 30; t++) begin
      randomize_inputs();
      mask = 4'($urandom_range(1, 15));
      r = $urandom_range(0, 9);
      mode = (r < 7) ? 0 : ((r < 9) ? 1 : 2);
      do_txn(mask, mode, $urandom_range(1, 4), $urandom_range(1, 20),
             8'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end

    // Reset during WAIT_DONE: transaction abandoned, no done.
    randomize_inputs();
    mask = 4'b0010;
    win = model_winner(mask);
    exp_q.push_back({3'(win), req_addr[win*AW +: AW], req_wdata[win*DW +: DW], 8'h00, 1'b0, 1'b0});
    plan_q.push_back({2'd0, 4'd1, 8'd20, 1'b1, 8'h77});
    exp_launch_q.push_back(cyc + 1);
    exp_done_q.push_back(cyc + 23);
    req = mask;
    repeat (6) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_gnt", 32'(gnt), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_m_start", 32'(m_start), 32'd0);
    check("midrst_rdata", 32'(rdata), 32'd0);
    check("midrst_m_addr", 32'(m_slave_addr), 32'd0);
    flush_model();
    last_gnt = N - 1;
    req = '0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    randomize_inputs();
    do_txn(4'b1001, 0, 1, 4, 8'h81, 1'b1, 1'b0);

    repeat (10) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_req_arbiter.md
I2C_REQ_ARBITER -- requirements
Module: i2c_req_arbiter

Interface
REQ-001 Parameter NUM_REQ, 4, number of requesters sharing one I2C master (2..8).
REQ-002 Parameter DATA_WIDTH, 8, I2C data byte width.
REQ-003 Parameter ADDR_WIDTH, 7, I2C slave address width.
REQ-004 Parameter TIMEOUT_CYCLES, 1023, clk cycles allowed per transaction before abort (max 65535).
REQ-005 One clock and one reset: reset is asynchronous and active-high.
REQ-006 clk  input  1  system clock; all state changes on its rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 req  input  NUM_REQ  per-requester transaction request level.
REQ-009 req_addr  input  NUM_REQ*ADDR_WIDTH  packed slave addresses; slice i belongs to requester i.
REQ-010 req_wdata  input  NUM_REQ*DATA_WIDTH  packed write bytes; slice i belongs to requester i.
REQ-011 gnt  output  NUM_REQ  one-hot grant; all-zero when no grant is active.
REQ-012 done  output  NUM_REQ  one-cycle completion pulse to the granted requester.
REQ-013 rdata  output  DATA_WIDTH  byte captured from the master at completion; shared by all requesters.
REQ-014 ack_o  output  1  slave acknowledge captured at completion.
REQ-015 err  output  1  one-cycle pulse coincident with done when the transaction timed out.
REQ-016 m_start  output  1  start strobe to the I2C master.
REQ-017 m_slave_addr  output  ADDR_WIDTH  address to the master.
REQ-018 m_data_in  output  DATA_WIDTH  write byte to the master.
REQ-019 m_data_out  input  DATA_WIDTH  read byte from the master.
REQ-020 m_busy  input  1  master busy flag.
REQ-021 m_ack  input  1  master acknowledge.

Function
REQ-022 The FSM SHALL have the states IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE and COMPLETE.
REQ-023 IDLE with any req bit set SHALL select the winner round-robin, starting the search at last_gnt+1 modulo NUM_REQ.
REQ-024 On that IDLE edge, the winner's address and data SHALL be latched into m_slave_addr/m_data_in, gnt set one-hot, and the FSM SHALL move to LAUNCH.
REQ-025 LAUNCH SHALL last exactly one cycle, during which m_start=1 and the timeout counter is cleared; the FSM then moves to WAIT_BUSY.
REQ-026 In WAIT_BUSY, m_busy=1 SHALL move the FSM to WAIT_DONE.
REQ-027 In WAIT_DONE, m_busy=0 SHALL move the FSM to COMPLETE and capture m_data_out into rdata and m_ack into ack_o.
REQ-028 The timeout counter SHALL increment each cycle in WAIT_BUSY/WAIT_DONE and saturate.
REQ-029 When the counter equals TIMEOUT_CYCLES, the FSM SHALL move to COMPLETE with err armed, rdata cleared to 0 and ack_o cleared to 0.
REQ-030 COMPLETE SHALL last one cycle: done[winner]=1, err=1 if armed, last_gnt updated to winner; gnt is cleared on exit and the FSM returns to IDLE.
REQ-031 m_slave_addr and m_data_in SHALL stay stable from LAUNCH through COMPLETE, ignoring changes on req_addr/req_wdata.
REQ-032 A requester dropping req while granted SHALL NOT abort the transaction; it still receives done.
REQ-033 Requests asserted in LAUNCH through COMPLETE SHALL be arbitrated only in the next IDLE cycle; consequently there is at least one idle cycle between transactions.
REQ-034 A requester holding req high after its done SHALL be treated as a new request and SHALL lose to any other pending requester.
REQ-035 Latency from req rising (in IDLE) to m_start SHALL be 1 cycle.
REQ-036 Latency from m_busy falling to done SHALL be 1 cycle.
REQ-037 At most one gnt bit and at most one done bit SHALL ever be high.
REQ-038 m_start SHALL never be high outside LAUNCH.

Reset
REQ-039 rst=1 SHALL immediately force state=IDLE and clear gnt, done, err, ack_o, rdata, m_start, m_slave_addr, m_data_in and the timeout counter.
REQ-040 rst=1 SHALL set last_gnt to NUM_REQ-1, so that requester 0 has first priority.
REQ-041 Reset mid-transaction SHALL abandon the transaction without a done pulse.

Verification
REQ-042 Single request: req=4'b0100, addr=7'h50, wdata=8'hA5 -> gnt=4'b0100; m_start high for one cycle with m_slave_addr=7'h50 and m_data_in=8'hA5; master busy for 20 cycles returning 8'h3C with ack=1 -> done=4'b0100 one cycle after busy falls, rdata=8'h3C, ack_o=1.
REQ-043 Contention: req=4'b1111 held, after reset -> grant order 0,1,2,3,0, each separated by COMPLETE+IDLE.
REQ-044 Timeout: TIMEOUT_CYCLES=15, m_busy stuck 0 after m_start -> done and err pulse together 16 cycles after LAUNCH, rdata=0, ack_o=0.
REQ-045 Stuck busy: m_busy held 1 past TIMEOUT_CYCLES -> err pulse; the next grant proceeds normally once busy drops.
REQ-046 Reset mid-transaction: assert rst during WAIT_DONE -> gnt=0 and no done; after release, req=4'b0001 is granted first.
REQ-047 Request drop and input changes: requester 2 drops req and changes req_addr during WAIT_BUSY -> m_slave_addr unchanged and done[2] still pulses.
